serial_sub_ctrl: RTL

Bit-serial subtraction sequencer for the eight-bit calculator. It accepts two WIDTH-bit operands through a start/done handshake. It then steps a single shared combinational 1-bit full-subtractor cell from LSB to MSB, one bit per clock, carrying the borrow between steps in a register. It sits between the calculator operand registers and the subtractor bit-cell, and returns the registered difference, final borrow and signed-overflow flag.

---
 rtl/serial_sub_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction sequencer: drives one shared 1-bit full-subtractor cell
// from LSB to MSB and returns the registered difference, final borrow and signed overflow.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_bin,
  input  logic             cell_d,
  input  logic             cell_bout
);

  localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_nxt;
  logic             bor_q, bor_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  // Newest cell result enters at the top; after the last bit this is the full difference.
  assign acc_nxt = {cell_d, acc_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      acc_q    <= '0;
      bor_q    <= 1'b0;
      idx_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      acc_q    <= acc_d;
      bor_q    <= bor_d;
      idx_q    <= idx_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and datapath update; result registers only move on the completion edge.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    acc_d    = acc_q;
    bor_d    = bor_q;
    idx_d    = idx_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sr_d  = a;
          b_sr_d  = b;
          bor_d   = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
        end
      end
      RUN: begin
        acc_d  = acc_nxt[WIDTH-1:1];
        bor_d  = cell_bout;
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          diff_d   = acc_nxt;
          borrow_d = cell_bout;
          ovf_d    = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Cell inputs are forced low whenever the sequencer is idle.
  assign cell_a   = (state_q == RUN) ? a_sr_q[0] : 1'b0;
  assign cell_b   = (state_q == RUN) ? b_sr_q[0] : 1'b0;
  assign cell_bin = (state_q == RUN) ? bor_q     : 1'b0;

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign ovf        = ovf_q;

endmodule
